// File: rtl/router_pkg.sv
// Shared constants and types for the router register block: default byte
// width, the reserved destination address, and the dout source selector.
package router_pkg;

    localparam int DATA_W_DEF = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [1:0] {
        DSRC_HOLD  = 2'b00,
        DSRC_HDR   = 2'b01,
        DSRC_DIN   = 2'b10,
        DSRC_STASH = 2'b11
    } dout_src_e;

    function automatic logic is_valid_addr(input logic [1:0] addr);
        return addr != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_reg_if.sv
// Bus between the router controller side and the register block: packet byte
// stream, one-hot controller state flags, and the FIFO-facing results.
interface router_reg_if #(
    parameter int DATA_W = router_pkg::DATA_W_DEF
);
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic              fifo_full;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              full_state;
    logic              laf_state;
    logic              rst_int_reg;
    logic [DATA_W-1:0] dout;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              err;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
        input  dout, parity_done, low_pkt_valid, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
        output dout, parity_done, low_pkt_valid, err
    );
endinterface

// File: rtl/router_parity_acc.sv
// Running XOR of the packet bytes and the captured trailing parity byte;
// reports whether the two disagree.
module router_parity_acc #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clr_i,
    input  logic              xor_en_i,
    input  logic [DATA_W-1:0] xor_val_i,
    input  logic              cap_en_i,
    input  logic [DATA_W-1:0] cap_val_i,
    output logic              mismatch_o
);
    logic [DATA_W-1:0] internal_parity_q, internal_parity_d;
    logic [DATA_W-1:0] packet_parity_q, packet_parity_d;

    always_comb begin
        internal_parity_d = internal_parity_q;
        packet_parity_d   = packet_parity_q;
        if (clr_i) begin
            internal_parity_d = '0;
        end else if (xor_en_i) begin
            internal_parity_d = internal_parity_q ^ xor_val_i;
        end
        if (cap_en_i) begin
            packet_parity_d = cap_val_i;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            internal_parity_q <= '0;
            packet_parity_q   <= '0;
        end else begin
            internal_parity_q <= internal_parity_d;
            packet_parity_q   <= packet_parity_d;
        end
    end

    assign mismatch_o = (internal_parity_q != packet_parity_q);

endmodule

// File: rtl/router_reg.sv
// Router register block: latches the header, forwards payload bytes to the
// destination FIFO (stashing one byte across a FIFO-full stall) and checks parity.
module router_reg import router_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic        clock,
    input  logic        resetn,
    router_reg_if.slave bus
);
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] header_q, header_d;
    logic [DATA_W-1:0] stash_q, stash_d;
    logic              stash_par_q, stash_par_d;
    logic              parity_done_q, parity_done_d;
    logic              low_pkt_valid_q, low_pkt_valid_d;
    logic              err_q, err_d;

    dout_src_e         dout_src;
    logic              ld_take;
    logic              ld_stall;
    logic              acc_clr;
    logic              acc_xor_en;
    logic [DATA_W-1:0] acc_xor_val;
    logic              acc_cap_en;
    logic [DATA_W-1:0] acc_cap_val;
    logic              acc_mismatch;

    assign ld_take  = bus.ld_state && !bus.fifo_full;
    assign ld_stall = bus.ld_state && bus.fifo_full;

    always_comb begin
        dout_src = DSRC_HOLD;
        if (bus.lfd_state) begin
            dout_src = DSRC_HDR;
        end else if (ld_take) begin
            dout_src = DSRC_DIN;
        end else if (bus.laf_state) begin
            dout_src = DSRC_STASH;
        end
    end

    always_comb begin
        dout_d          = dout_q;
        header_d        = header_q;
        stash_d         = stash_q;
        stash_par_d     = stash_par_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;
        err_d           = err_q;
        acc_clr         = 1'b0;
        acc_xor_en      = 1'b0;
        acc_xor_val     = header_q;
        acc_cap_en      = 1'b0;
        acc_cap_val     = stash_q;

        // full_state freezes everything, including the parity accumulator.
        if (!bus.full_state) begin
            case (dout_src)
                DSRC_HDR:   dout_d = header_q;
                DSRC_DIN:   dout_d = bus.data_in;
                DSRC_STASH: dout_d = stash_q;
                default:    dout_d = dout_q;
            endcase

            if (bus.detect_add && bus.pkt_valid && is_valid_addr(bus.data_in[1:0])) begin
                header_d = bus.data_in;
            end

            // The stalled byte remembers whether it was the parity byte.
            if (ld_stall) begin
                stash_d     = bus.data_in;
                stash_par_d = !bus.pkt_valid;
            end

            acc_clr = bus.detect_add;
            if (bus.lfd_state) begin
                acc_xor_en  = 1'b1;
                acc_xor_val = header_q;
            end else if (ld_take && bus.pkt_valid) begin
                acc_xor_en  = 1'b1;
                acc_xor_val = bus.data_in;
            end else if (bus.laf_state && !stash_par_q) begin
                acc_xor_en  = 1'b1;
                acc_xor_val = stash_q;
            end

            if (ld_take && !bus.pkt_valid) begin
                acc_cap_en  = 1'b1;
                acc_cap_val = bus.data_in;
            end else if (bus.laf_state && stash_par_q) begin
                acc_cap_en  = 1'b1;
                acc_cap_val = stash_q;
            end

            if (bus.detect_add) begin
                parity_done_d = 1'b0;
            end else if (acc_cap_en && !parity_done_q) begin
                parity_done_d = 1'b1;
            end

            if (bus.rst_int_reg) begin
                low_pkt_valid_d = 1'b0;
            end else if ((bus.ld_state || bus.laf_state) && !bus.pkt_valid) begin
                low_pkt_valid_d = 1'b1;
            end

            if (bus.rst_int_reg && parity_done_q) begin
                err_d = acc_mismatch;
            end else if (bus.detect_add && bus.pkt_valid) begin
                err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            dout_q          <= '0;
            header_q        <= '0;
            stash_q         <= '0;
            stash_par_q     <= 1'b0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            dout_q          <= dout_d;
            header_q        <= header_d;
            stash_q         <= stash_d;
            stash_par_q     <= stash_par_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            err_q           <= err_d;
        end
    end

    router_parity_acc #(
        .DATA_W (DATA_W)
    ) u_parity_acc (
        .clock      (clock),
        .resetn     (resetn),
        .clr_i      (acc_clr),
        .xor_en_i   (acc_xor_en),
        .xor_val_i  (acc_xor_val),
        .cap_en_i   (acc_cap_en),
        .cap_val_i  (acc_cap_val),
        .mismatch_o (acc_mismatch)
    );

    assign bus.dout          = dout_q;
    assign bus.parity_done   = parity_done_q;
    assign bus.low_pkt_valid = low_pkt_valid_q;
    assign bus.err           = err_q;

endmodule

// File: doc/router_reg.md
ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte width of data path.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have port pkt_valid  input  1  packet byte valid; falling with parity byte.
REQ-005 SHALL have port data_in  input  DATA_W  packet byte; header = {len[7:2], addr[1:0]}.
REQ-006 SHALL have port fifo_full  input  1  selected destination FIFO full.
REQ-007 SHALL have ports detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg  input  1 each  one-hot controller state flags.
REQ-008 SHALL have port dout  output  DATA_W  byte to destination FIFO.
REQ-009 SHALL have port parity_done  output  1  parity byte delivered to dout.
REQ-010 SHALL have port low_pkt_valid  output  1  pkt_valid has fallen for current packet.
REQ-011 SHALL have port err  output  1  parity mismatch for last packet.

Function
REQ-012 SHALL capture header_byte <= data_in when detect_add && pkt_valid && data_in[1:0] != 2'b11.
REQ-013 SHALL drive dout <= header_byte in lfd_state (1-cycle latency from capture).
REQ-014 SHALL drive dout <= data_in when ld_state && !fifo_full.
REQ-015 SHALL, when ld_state && fifo_full, hold dout, capture stash <= data_in and stash_par <= !pkt_valid.
REQ-016 SHALL drive dout <= stash in laf_state; hold dout in all other cases.
REQ-017 SHALL clear internal_parity in detect_add; XOR header_byte in lfd_state.
REQ-018 SHALL XOR data_in into internal_parity when ld_state && !fifo_full && pkt_valid.
REQ-019 SHALL XOR stash into internal_parity in laf_state when stash_par == 0.
REQ-020 SHALL capture packet_parity <= data_in when ld_state && !fifo_full && !pkt_valid, or <= stash in laf_state when stash_par == 1.
REQ-021 SHALL set parity_done on the same edge as REQ-020 capture; clear in detect_add; parity_done has priority-hold (no re-set while already 1).
REQ-022 SHALL set low_pkt_valid when (ld_state || laf_state) && !pkt_valid; clear when rst_int_reg.
REQ-023 SHALL, when rst_int_reg && parity_done, load err <= (internal_parity != packet_parity).
REQ-024 SHALL clear err when detect_add && pkt_valid (new packet start); otherwise hold.
REQ-025 SHALL ignore fifo_full outside ld_state; full_state SHALL freeze all internal registers and dout.
REQ-026 SHALL ignore header with addr 2'b11 (header_byte unchanged).
REQ-027 SHALL treat simultaneous set/clear: clear wins for low_pkt_valid (rst_int_reg) and parity_done (detect_add).

Reset
REQ-028 SHALL, when resetn == 0 at a clock edge, clear dout, header_byte, stash, stash_par, internal_parity, packet_parity, parity_done, low_pkt_valid, err to 0.
REQ-029 SHALL abandon any in-flight packet on reset mid-operation; first post-reset header SHALL be processed normally.

Structure
REQ-030 SHALL take DATA_W default and ADDR_INVALID = 2'b11 from shared package router_pkg.
REQ-031 SHALL be a single module; optional sub-module router_parity_acc holds internal_parity/packet_parity compare.

Verification
REQ-032 Header 8'h0D (len 3, addr 1), payload 11,22,33, parity 8'h0D^11^22^33 = 8'h0D, no full -> dout sequence 0D,11,22,33,0D; parity_done=1; err=0 after rst_int_reg.
REQ-033 Same packet with parity 8'hFF -> err=1 after rst_int_reg; next header with pkt_valid clears err to 0.
REQ-034 fifo_full=1 during ld_state while data_in=8'h22 -> dout held at 11; laf_state -> dout=22; final parity still correct, err=0.
REQ-035 fifo_full=1 on parity byte -> stash_par=1; laf_state -> dout=parity, parity_done=1 in laf cycle, low_pkt_valid=1.
REQ-036 Header 8'h07 (addr 3) in detect_add -> header_byte unchanged, dout unchanged.
REQ-037 resetn=0 mid-payload -> all outputs 0 next edge; subsequent packet 8'h04, 8'hAA, parity 8'hAE -> err=0.
